// File: rtl/gray_seq_monitor_pkg.sv
// Shared definitions for the Gray sequence monitor.
//   - state encoding for the lock FSM
//   - the eight code words of the upstream 8-state Gray sequencer
//   - code -> position decode and legal-successor helper functions
package gray_seq_monitor_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StAcquire = ACQUIRE,
        StLocked  = LOCKED
    } state_e;

    // Code word for each sequence position.
    localparam logic [2:0] CODE_P0 = 3'b100;
    localparam logic [2:0] CODE_P1 = 3'b101;
    localparam logic [2:0] CODE_P2 = 3'b111;
    localparam logic [2:0] CODE_P3 = 3'b110;
    localparam logic [2:0] CODE_P4 = 3'b010;
    localparam logic [2:0] CODE_P5 = 3'b011;
    localparam logic [2:0] CODE_P6 = 3'b001;
    localparam logic [2:0] CODE_P7 = 3'b000;

    function automatic logic [2:0] gray_decode(input logic [2:0] code);
        logic [2:0] p;
        case (code)
            CODE_P0: p = 3'd0;
            CODE_P1: p = 3'd1;
            CODE_P2: p = 3'd2;
            CODE_P3: p = 3'd3;
            CODE_P4: p = 3'd4;
            CODE_P5: p = 3'd5;
            CODE_P6: p = 3'd6;
            default: p = 3'd7;
        endcase
        return p;
    endfunction

    // Code word that legally follows 'code'; position 7 wraps to position 0.
    function automatic logic [2:0] gray_succ(input logic [2:0] code);
        logic [2:0] n;
        case (code)
            CODE_P0: n = CODE_P1;
            CODE_P1: n = CODE_P2;
            CODE_P2: n = CODE_P3;
            CODE_P3: n = CODE_P4;
            CODE_P4: n = CODE_P5;
            CODE_P5: n = CODE_P6;
            CODE_P6: n = CODE_P7;
            default: n = CODE_P0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gray_seq_monitor_decode.sv
// gray_pos_decode: combinational step classifier.
//   code      in  : current code word
//   prev_code in  : previously sampled code word
//   pos       out : decoded position of code
//   is_succ   out : code is the legal successor of prev_code
//   is_hold   out : code repeats prev_code
module gray_pos_decode
    import gray_seq_monitor_pkg::*;
(
    input  logic [2:0] code,
    input  logic [2:0] prev_code,
    output logic [2:0] pos,
    output logic       is_succ,
    output logic       is_hold
);

    assign pos     = gray_decode(code);
    assign is_succ = (code == gray_succ(prev_code));
    assign is_hold = (code == prev_code);

endmodule

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: tracks a 3-bit Gray sequence, locks after LOCK_STEPS
// consecutive legal steps, and counts laps and step errors while locked.
//   clk       in  : rising-edge clock
//   reset_n   in  : asynchronous active-low reset
//   sample_en in  : qualifies code_in
//   code_in   in  : code word from the sequencer
//   clr_cnt   in  : synchronous clear of lap_cnt / err_cnt
//   pos       out : position of the last sampled code
//   locked    out : FSM is in LOCKED
//   step_err  out : one-cycle pulse on an illegal step while locked
//   lap_pulse out : one-cycle pulse on a locked 7 -> 0 step
//   lap_cnt   out : completed laps, wrapping
//   err_cnt   out : step errors, saturating at 255
module gray_seq_monitor
    import gray_seq_monitor_pkg::*;
#(
    parameter int unsigned LOCK_STEPS = 4,
    parameter int unsigned LAP_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic [2:0]       code_in,
    input  logic             clr_cnt,
    output logic [2:0]       pos,
    output logic             locked,
    output logic             step_err,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [7:0]       err_cnt
);

    localparam logic [3:0] LockSteps = 4'(LOCK_STEPS);

    state_e     state;
    logic [2:0] prev_code;
    logic [3:0] good_cnt;

    logic [2:0] dec_pos;
    logic       is_succ;
    logic       is_hold;

    gray_pos_decode u_decode (
        .code      (code_in),
        .prev_code (prev_code),
        .pos       (dec_pos),
        .is_succ   (is_succ),
        .is_hold   (is_hold)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            prev_code <= CODE_P0;
            pos       <= 3'd0;
            good_cnt  <= 4'd0;
            locked    <= 1'b0;
            step_err  <= 1'b0;
            lap_pulse <= 1'b0;
            lap_cnt   <= '0;
            err_cnt   <= 8'd0;
        end else begin
            step_err  <= 1'b0;
            lap_pulse <= 1'b0;
            if (sample_en) begin
                prev_code <= code_in;
                pos       <= dec_pos;
                case (state)
                    StIdle: begin
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                        state    <= StAcquire;
                    end
                    StAcquire: begin
                        if (is_succ) begin
                            if (good_cnt + 4'd1 == LockSteps) begin
                                good_cnt <= 4'd0;
                                locked   <= 1'b1;
                                state    <= StLocked;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else if (!is_hold) begin
                            good_cnt <= 4'd0;
                        end
                    end
                    StLocked: begin
                        if (is_succ) begin
                            // Only the 7 -> 0 step completes a lap.
                            if (code_in == CODE_P0) begin
                                lap_pulse <= 1'b1;
                                lap_cnt   <= lap_cnt + LAP_W'(1);
                            end
                        end else if (!is_hold) begin
                            step_err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            good_cnt <= 4'd0;
                            locked   <= 1'b0;
                            state    <= StAcquire;
                        end
                    end
                    default: begin
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                        state    <= StIdle;
                    end
                endcase
            end
            // Placed last so a clear overrides any increment on the same edge.
            if (clr_cnt) begin
                lap_cnt <= '0;
                err_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_monitor.sv
module tb_gray_seq_monitor;

    logic       clk;
    logic       reset_n;
    logic       sample_en;
    logic [2:0] code_in;
    logic       clr_cnt;
    logic [2:0] pos;
    logic       locked;
    logic       step_err;
    logic       lap_pulse;
    logic [7:0] lap_cnt;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    gray_seq_monitor #(
        .LOCK_STEPS (4),
        .LAP_W      (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .code_in   (code_in),
        .clr_cnt   (clr_cnt),
        .pos       (pos),
        .locked    (locked),
        .step_err  (step_err),
        .lap_pulse (lap_pulse),
        .lap_cnt   (lap_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] enc(input int p);
        logic [2:0] c;
        case (p % 8)
            0: c = 3'b100;
            1: c = 3'b101;
            2: c = 3'b111;
            3: c = 3'b110;
            4: c = 3'b010;
            5: c = 3'b011;
            6: c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic drive(input logic [2:0] c, input logic en, input logic clr);
        @(negedge clk);
        code_in   = c;
        sample_en = en;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic good_step();
        cur = (cur + 1) % 8;
        drive(enc(cur), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        sample_en = 1'b0;
        code_in   = 3'b000;
        clr_cnt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({pos, locked, step_err, lap_pulse} !== 6'd0) begin
            bad++;
            $display("FAIL reset_flags got pos=%0d lk=%0b se=%0b lp=%0b want all 0",
                     pos, locked, step_err, lap_pulse);
        end
        total++;
        if (lap_cnt !== 8'd0 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_cnt got lap=%0d err=%0d want 0 0", lap_cnt, err_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        cur = 0;
        drive(enc(0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) good_step();
        total++;
        if (locked !== 1'b0 || pos !== 3'd3) begin
            bad++;
            $display("FAIL lock_early got lk=%0b pos=%0d want 0 3", locked, pos);
        end
        good_step();
        total++;
        if (locked !== 1'b1 || pos !== 3'd4 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL lock_4 got lk=%0b pos=%0d se=%0b want 1 4 0", locked, pos, step_err);
        end
    endtask

    task automatic test_lap();
        for (int i = 0; i < 3; i++) good_step();
        total++;
        if (lap_pulse !== 1'b0 || lap_cnt !== 8'd0 || pos !== 3'd7) begin
            bad++;
            $display("FAIL lap_pre got lp=%0b lap=%0d pos=%0d want 0 0 7", lap_pulse, lap_cnt, pos);
        end
        good_step();
        total++;
        if (lap_pulse !== 1'b1 || lap_cnt !== 8'd1 || pos !== 3'd0) begin
            bad++;
            $display("FAIL lap_one got lp=%0b lap=%0d pos=%0d want 1 1 0", lap_pulse, lap_cnt, pos);
        end
        drive(enc(0), 1'b0, 1'b0);
        total++;
        if (lap_pulse !== 1'b0 || lap_cnt !== 8'd1) begin
            bad++;
            $display("FAIL lap_pulse_len got lp=%0b lap=%0d want 0 1", lap_pulse, lap_cnt);
        end
    endtask

    task automatic test_error();
        good_step();
        good_step();
        cur = 4;
        drive(enc(4), 1'b1, 1'b0);
        total++;
        if (step_err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || pos !== 3'd4) begin
            bad++;
            $display("FAIL err_step got se=%0b err=%0d lk=%0b pos=%0d want 1 1 0 4",
                     step_err, err_cnt, locked, pos);
        end
        good_step();
        total++;
        if (step_err !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_len got se=%0b want 0", step_err);
        end
        good_step();
        // Bad step in ACQUIRE: no error counted, good count restarts.
        cur = 4;
        drive(enc(4), 1'b1, 1'b0);
        total++;
        if (step_err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL acq_bad got se=%0b err=%0d lk=%0b want 0 1 0", step_err, err_cnt, locked);
        end
        for (int i = 0; i < 3; i++) good_step();
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL relock_early got lk=%0b want 0", locked);
        end
        good_step();
        total++;
        if (locked !== 1'b1 || lap_pulse !== 1'b0 || lap_cnt !== 8'd1 || pos !== 3'd0) begin
            bad++;
            $display("FAIL relock_no_lap got lk=%0b lp=%0b lap=%0d pos=%0d want 1 0 1 0",
                     locked, lap_pulse, lap_cnt, pos);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) good_step();
        for (int i = 0; i < 5; i++) begin
            drive(enc(3), 1'b1, 1'b0);
            total++;
            if (step_err !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d got se=%0b lk=%0b want 0 1", i, step_err, locked);
            end
            drive(enc(6), 1'b0, 1'b0);
        end
        total++;
        if (pos !== 3'd3 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL hold_end got pos=%0d err=%0d lk=%0b want 3 1 1", pos, err_cnt, locked);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 254; i++) begin
            cur = (cur + 2) % 8;
            drive(enc(cur), 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) good_step();
        end
        total++;
        if (err_cnt !== 8'd255 || locked !== 1'b1) begin
            bad++;
            $display("FAIL sat_fill got err=%0d lk=%0b want 255 1", err_cnt, locked);
        end
        cur = (cur + 2) % 8;
        drive(enc(cur), 1'b1, 1'b0);
        total++;
        if (step_err !== 1'b1 || err_cnt !== 8'd255 || locked !== 1'b0) begin
            bad++;
            $display("FAIL sat_hold got se=%0b err=%0d lk=%0b want 1 255 0",
                     step_err, err_cnt, locked);
        end
        for (int j = 0; j < 4; j++) good_step();
        while (cur != 7) good_step();
        total++;
        if (lap_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL sat_prelap got lap=%0d lk=%0b want 1 1", lap_cnt, locked);
        end
        cur = 0;
        drive(enc(0), 1'b1, 1'b1);
        total++;
        if (lap_pulse !== 1'b1 || lap_cnt !== 8'd0 || err_cnt !== 8'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL clr_vs_lap got lp=%0b lap=%0d err=%0d lk=%0b want 1 0 0 1",
                     lap_pulse, lap_cnt, err_cnt, locked);
        end
    endtask

    task automatic test_clr_idle();
        for (int i = 0; i < 8; i++) good_step();
        total++;
        if (lap_cnt !== 8'd1) begin
            bad++;
            $display("FAIL clr_pre got lap=%0d want 1", lap_cnt);
        end
        drive(enc(5), 1'b0, 1'b1);
        total++;
        if (lap_cnt !== 8'd0 || locked !== 1'b1 || pos !== 3'd0) begin
            bad++;
            $display("FAIL clr_no_sample got lap=%0d lk=%0b pos=%0d want 0 1 0",
                     lap_cnt, locked, pos);
        end
    endtask

    task automatic test_lap_wrap();
        for (int i = 0; i < 255 * 8; i++) good_step();
        total++;
        if (lap_cnt !== 8'd255) begin
            bad++;
            $display("FAIL wrap_255 got lap=%0d want 255", lap_cnt);
        end
        for (int i = 0; i < 8; i++) good_step();
        total++;
        if (lap_cnt !== 8'd0 || lap_pulse !== 1'b1) begin
            bad++;
            $display("FAIL wrap_0 got lap=%0d lp=%0b want 0 1", lap_cnt, lap_pulse);
        end
    endtask

    task automatic test_async_reset();
        good_step();
        good_step();
        drive(enc(1), 1'b0, 1'b1);
        good_step();
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({pos, locked, step_err, lap_pulse} !== 6'd0 || lap_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_rst got pos=%0d lk=%0b se=%0b lp=%0b lap=%0d want 0",
                     pos, locked, step_err, lap_pulse, lap_cnt);
        end
        #4;
        reset_n = 1'b1;
        cur = 6;
        drive(enc(6), 1'b1, 1'b0);
        total++;
        if (step_err !== 1'b0 || locked !== 1'b0 || pos !== 3'd6 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL post_rst got se=%0b lk=%0b pos=%0d err=%0d want 0 0 6 0",
                     step_err, locked, pos, err_cnt);
        end
        good_step();
        good_step();
        total++;
        if (lap_pulse !== 1'b0 || lap_cnt !== 8'd0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_lap got lp=%0b lap=%0d lk=%0b want 0 0 0",
                     lap_pulse, lap_cnt, locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_lap();
        test_error();
        test_hold();
        test_saturate();
        test_clr_idle();
        test_lap_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_seq_monitor.md
GRAY_SEQ_MONITOR -- requirements
Module: gray_seq_monitor

Interface
REQ-001 Parameter LOCK_STEPS, default 4: number of consecutive legal steps required to assert lock (range 1..15).
REQ-002 Parameter LAP_W, default 8: width of the lap counter.
REQ-003 One clock; reset is asynchronous and active-low. The ports are listed below, clock and reset first.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 sample_en  input  1  qualifies code_in on this edge; when low, nothing changes.
REQ-007 code_in  input  3  code word from the upstream 8-state Gray sequencer.
REQ-008 clr_cnt  input  1  synchronous clear of lap_cnt and err_cnt.
REQ-009 pos  output  3  decoded sequence position of the last sampled code.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 step_err  output  1  one-cycle pulse on an illegal step while LOCKED.
REQ-012 lap_pulse  output  1  one-cycle pulse on a locked wrap from position 7 to position 0.
REQ-013 lap_cnt  output  LAP_W  count of completed laps, wrapping modulo 2^LAP_W.
REQ-014 err_cnt  output  8  count of step_err events, saturating at 255.

Function
REQ-015 The decode table SHALL be: 100->0, 101->1, 111->2, 110->3, 010->4, 011->5, 001->6, 000->7.
REQ-016 The legal successor of position p SHALL be (p+1) mod 8, so 000 is followed by 100.
REQ-017 All outputs SHALL be registered, updating on the clk edge that samples code_in (one-cycle latency).
REQ-018 When sample_en=0, all state and outputs SHALL hold, and step_err and lap_pulse SHALL be 0.
REQ-019 The FSM SHALL have three states: IDLE (no previous code), ACQUIRE (no lock yet) and LOCKED.
REQ-020 IDLE, on a sample: store prev_code, update pos, clear good_cnt, go to ACQUIRE; no step check is made.
REQ-021 Step classification, for every sample outside IDLE:
  - good: code_in equals the successor of prev_code.
  - hold: code_in equals prev_code.
  - bad: any other value.
REQ-022 prev_code and pos SHALL update on every sample, whatever the classification.
REQ-023 ACQUIRE SHALL act on each step type as follows:
  - good: good_cnt increments; on reaching LOCK_STEPS, go to LOCKED.
  - hold: no change.
  - bad: good_cnt is cleared and the FSM stays in ACQUIRE.
REQ-024 LOCKED SHALL act on each step type as follows:
  - good or hold: stay in LOCKED.
  - bad: pulse step_err, increment err_cnt (saturating), go to ACQUIRE with good_cnt=0.
REQ-025 A good step 000->100 while LOCKED SHALL pulse lap_pulse and increment lap_cnt; lap_cnt wraps from all-ones to 0.
REQ-026 A lap or error SHALL NOT be counted in IDLE or ACQUIRE, including on the step that causes the entry to LOCKED.
REQ-027 clr_cnt=1 SHALL zero lap_cnt and err_cnt; clear wins over a simultaneous increment, but the pulses still fire.
REQ-028 clr_cnt SHALL act regardless of sample_en and SHALL NOT affect the FSM, pos or prev_code.
REQ-029 A bad step when err_cnt=255 SHALL pulse step_err and leave err_cnt at 255.

Reset
REQ-030 Asserting reset_n low SHALL immediately force: state=IDLE, pos=0, prev_code=100, good_cnt=0, locked=0, step_err=0, lap_pulse=0, lap_cnt=0, err_cnt=0.
REQ-031 Reset asserted mid-lap SHALL discard the lock; after release the first sample SHALL be treated as an IDLE sample.

Structure
REQ-032 A shared package SHALL hold:
  - the state encoding localparams (IDLE, ACQUIRE, LOCKED);
  - the eight code constants;
  - the decode function code->pos and the successor function.
REQ-033 One sub-module, gray_pos_decode (combinational, code to pos plus a legal-successor flag), is natural; everything else lives in gray_seq_monitor.

Verification
REQ-034 Reset, then the codes 100,101,111,110,010 with sample_en=1 SHALL give: locked=1 one cycle after the 010 sample (4 good steps), with pos=4.
REQ-035 When locked, a continued sequence through 000 then 100 SHALL give: lap_pulse=1 for exactly one cycle, with lap_cnt=1 and pos=0.
REQ-036 When locked at 111, a sample of 010 SHALL give: step_err pulse, err_cnt=1, locked=0; relock SHALL need 4 further good steps.
REQ-037 Holding code 110 for 5 samples, with sample_en toggled, SHALL produce: no error, locked unchanged, pos=3.
REQ-038 With err_cnt preloaded to 255 by 255 bad steps, one more bad step SHALL keep err_cnt at 255, and clr_cnt=1 on the same cycle as the next lap SHALL give lap_cnt=0.
REQ-039 reset_n pulsed low for a half cycle mid-sequence SHALL give: all outputs at reset values asynchronously, and the next sample SHALL not flag an error.
